// File: rtl/hdc_im_fetch_scheduler.sv
`default_nettype none
// ============================================================================
// hdc_im_fetch_scheduler: round-robin sharing of one item-memory SRAM read
// port among three modality encoders, one channel-sequential frame per grant.
// Revision: 1.0
// ============================================================================
module hdc_im_fetch_scheduler #(
   parameter int HV_DIMENSION = 2000,
   parameter int CHANNELS     = 4,
   parameter int CH_WIDTH     = 2
) (
   input  logic                    Clk_CI,
   input  logic                    Reset_RI,
   input  logic [2:0]              Req_SI,
   output logic [2:0]              Grant_SO,
   output logic [2:0]              Done_SO,
   output logic                    Busy_SO,
   output logic                    SramReq_SO,
   input  logic                    SramReady_SI,
   output logic [CH_WIDTH+1:0]     SramAddr_DO,
   input  logic                    SramValid_SI,
   input  logic [HV_DIMENSION-1:0] SramData_DI,
   output logic                    DataValid_SO,
   input  logic                    DataReady_SI,
   output logic [HV_DIMENSION-1:0] Data_DO,
   output logic [1:0]              DataMod_DO,
   output logic [CH_WIDTH-1:0]     DataCh_DO
);

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] ISSUE   = 2'd1;
   localparam logic [1:0] WAIT    = 2'd2;
   localparam logic [1:0] DELIVER = 2'd3;

   localparam logic [CH_WIDTH-1:0] LAST_CH = CH_WIDTH'(CHANNELS - 1);

   logic [1:0]          state;
   logic [1:0]          state_nxt;
   logic [1:0]          mod;
   logic [1:0]          last;
   logic [1:0]          pick;
   logic [CH_WIDTH-1:0] ch;
   logic                last_word;
   logic                accept;

   assign last_word = (ch == LAST_CH);
   assign accept    = (state == DELIVER) && DataReady_SI;

   // Search starts at the modality after the one served last, wrapping at 3.
   always_comb begin
      pick = 2'd0;
      case (last)
         2'd0:    pick = Req_SI[1] ? 2'd1 : (Req_SI[2] ? 2'd2 : 2'd0);
         2'd1:    pick = Req_SI[2] ? 2'd2 : (Req_SI[0] ? 2'd0 : 2'd1);
         default: pick = Req_SI[0] ? 2'd0 : (Req_SI[1] ? 2'd1 : 2'd2);
      endcase
   end

   always_ff @(posedge Clk_CI) begin
      if (!Reset_RI) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (Req_SI != 3'b000) state_nxt = ISSUE;
         ISSUE:   if (SramReady_SI)     state_nxt = WAIT;
         WAIT:    if (SramValid_SI)     state_nxt = DELIVER;
         DELIVER: if (DataReady_SI)     state_nxt = last_word ? IDLE : ISSUE;
         default:                       state_nxt = IDLE;
      endcase
   end

   always_comb begin
      Grant_SO     = (state != IDLE) ? (3'b001 << mod) : 3'b000;
      Done_SO      = (accept && last_word) ? (3'b001 << mod) : 3'b000;
      Busy_SO      = (state != IDLE);
      SramReq_SO   = (state == ISSUE);
      SramAddr_DO  = (state == ISSUE) ? {mod, ch} : '0;
      DataValid_SO = (state == DELIVER);
   end

   always_ff @(posedge Clk_CI) begin
      if (!Reset_RI) begin
         mod        <= 2'd0;
         last       <= 2'd2;
         ch         <= '0;
         Data_DO    <= '0;
         DataMod_DO <= 2'd0;
         DataCh_DO  <= '0;
      end else begin
         if ((state == IDLE) && (Req_SI != 3'b000)) begin
            mod <= pick;
            ch  <= '0;
         end
         if ((state == WAIT) && SramValid_SI) begin
            Data_DO    <= SramData_DI;
            DataMod_DO <= mod;
            DataCh_DO  <= ch;
         end
         if (accept) begin
            if (last_word) begin
               last <= mod;
            end else begin
               ch <= ch + 1'b1;
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_hdc_im_fetch_scheduler.sv
`default_nettype none
// ============================================================================
// tb_hdc_im_fetch_scheduler: randomized bench with a frame/transaction model.
// Revision: 1.0
// ============================================================================
module tb_hdc_im_fetch_scheduler;

   localparam int HV  = 2000;
   localparam int CHN = 4;
   localparam int CHW = 2;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [2:0]        req = 3'b000;
   logic [2:0]        grant, done;
   logic              busy, sreq, dvalid;
   logic              sready = 1'b0, svalid = 1'b0, dready = 1'b0;
   logic [CHW+1:0]    saddr;
   logic [HV-1:0]     sdata = '0;
   logic [HV-1:0]     dout;
   logic [1:0]        dmod;
   logic [CHW-1:0]    dch;

   always #5 clk = ~clk;

   hdc_im_fetch_scheduler #(.HV_DIMENSION(HV), .CHANNELS(CHN), .CH_WIDTH(CHW)) dut (
      .Clk_CI(clk), .Reset_RI(rst_n), .Req_SI(req), .Grant_SO(grant), .Done_SO(done),
      .Busy_SO(busy), .SramReq_SO(sreq), .SramReady_SI(sready), .SramAddr_DO(saddr),
      .SramValid_SI(svalid), .SramData_DI(sdata), .DataValid_SO(dvalid),
      .DataReady_SI(dready), .Data_DO(dout), .DataMod_DO(dmod), .DataCh_DO(dch)
   );

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;
   bit chk_en = 0;

   // stimulus knobs
   int p_sready = 100, p_dready = 100, ready_lat = 0, valid_lat = 0;
   bit valid_rand = 0, spurious = 0;
   int dready_hold = 0, req_cnt = 0;

   // transaction-level model
   bit            m_busy = 0, m_pend = 0, m_have = 0;
   int            m_mod = 0, m_ch = 0, m_last = 2, m_delay = 0, m_done = 0;
   logic [HV-1:0] m_pend_word = '0, m_word = '0;

   // observed DUT activity
   int         obs_addr_q[$], obs_ch_q[$], obs_frame_q[$];
   int         obs_done_cnt = 0, obs_acc_cnt = 0, obs_grant_cnt = 0, obs_sreq_cyc = 0;
   int         obs_done_cyc = 0, obs_grant_cyc = 0;
   logic [2:0] obs_done_val = 3'b000, prev_grant = 3'b000;

   function automatic logic [HV-1:0] rand_word();
      logic [HV-1:0] w = '0;
      for (int i = 0; i < HV; i += 32) w = (w << 32) | HV'($urandom);
      return w;
   endfunction

   function automatic int rr_pick(int lst, logic [2:0] r);
      for (int k = 1; k <= 3; k++) if (r[(lst + k) % 3]) return (lst + k) % 3;
      return 0;
   endfunction

   task automatic clear_logs();
      obs_addr_q.delete(); obs_ch_q.delete(); obs_frame_q.delete();
      obs_done_cnt = 0; obs_acc_cnt = 0; obs_grant_cnt = 0; obs_sreq_cyc = 0;
      obs_done_val = 3'b000; m_done = 0;
   endtask

   // One clock: drive SRAM/encoder side, compare against the model, advance it.
   task automatic tick();
      logic [2:0]     exp_grant, exp_done;
      logic [CHW+1:0] exp_addr;
      bit             exp_sreq;
      @(negedge clk);
      sready = 1'b0;
      if (sreq) begin
         if (req_cnt >= ready_lat && $urandom_range(99) < p_sready) sready = 1'b1;
      end else begin
         sready = 1'($urandom_range(1));
      end
      if (m_pend && m_delay == 0) begin
         svalid = 1'b1; sdata = m_pend_word;
      end else if (!m_pend && spurious && $urandom_range(2) == 0) begin
         svalid = 1'b1; sdata = rand_word();
      end else begin
         svalid = 1'b0; sdata = rand_word();
      end
      if (dready_hold > 0) begin
         dready = 1'b0; dready_hold--;
      end else begin
         dready = ($urandom_range(99) < p_dready);
      end
      #1;
      exp_sreq  = m_busy && !m_pend && !m_have;
      exp_grant = m_busy ? 3'(1 << m_mod) : 3'b000;
      exp_done  = (m_have && dready && m_ch == CHN - 1) ? 3'(1 << m_mod) : 3'b000;
      exp_addr  = (CHW + 2)'((m_mod << CHW) | m_ch);
      if (chk_en) begin
         n_cmp++; if (grant !== exp_grant) begin n_err++; $display("FAIL grant cyc=%0d got=%b exp=%b", cyc, grant, exp_grant); end
         n_cmp++; if (busy !== m_busy) begin n_err++; $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, busy, m_busy); end
         n_cmp++; if (sreq !== exp_sreq) begin n_err++; $display("FAIL sram_req cyc=%0d got=%b exp=%b", cyc, sreq, exp_sreq); end
         if (exp_sreq) begin
            n_cmp++; if (saddr !== exp_addr) begin n_err++; $display("FAIL sram_addr cyc=%0d got=%h exp=%h", cyc, saddr, exp_addr); end
         end
         n_cmp++; if (dvalid !== m_have) begin n_err++; $display("FAIL data_valid cyc=%0d got=%b exp=%b", cyc, dvalid, m_have); end
         if (m_have) begin
            n_cmp++; if (dout !== m_word) begin n_err++; $display("FAIL data cyc=%0d got[31:0]=%h exp[31:0]=%h", cyc, dout[31:0], m_word[31:0]); end
            n_cmp++; if (dmod !== 2'(m_mod) || dch !== CHW'(m_ch)) begin n_err++; $display("FAIL data_tag cyc=%0d got=%0d/%0d exp=%0d/%0d", cyc, dmod, dch, m_mod, m_ch); end
         end
         n_cmp++; if (done !== exp_done) begin n_err++; $display("FAIL done cyc=%0d got=%b exp=%b", cyc, done, exp_done); end
      end
      if (sreq && sready) obs_addr_q.push_back(int'(saddr));
      if (dvalid && dready) begin obs_ch_q.push_back(int'(dch)); obs_acc_cnt++; end
      if (done != 3'b000) begin obs_done_cnt++; obs_done_val = done; obs_done_cyc = cyc; end
      if (grant != 3'b000 && prev_grant == 3'b000) begin obs_frame_q.push_back(int'(grant)); obs_grant_cyc = cyc; end
      if (grant != 3'b000) obs_grant_cnt++;
      if (sreq) obs_sreq_cyc++;
      prev_grant = grant;
      if (sreq && !sready) req_cnt++; else req_cnt = 0;
      if (!rst_n) begin
         m_busy = 0; m_pend = 0; m_have = 0; m_last = 2; req_cnt = 0;
      end else if (!m_busy) begin
         if (req != 3'b000) begin m_mod = rr_pick(m_last, req); m_ch = 0; m_busy = 1; end
      end else if (exp_sreq) begin
         if (sready) begin
            m_pend = 1; m_pend_word = rand_word();
            m_delay = valid_rand ? $urandom_range(valid_lat) : valid_lat;
         end
      end else if (m_pend) begin
         if (m_delay == 0) begin m_pend = 0; m_have = 1; m_word = m_pend_word; end
         else m_delay--;
      end else if (m_have && dready) begin
         m_have = 0;
         if (m_ch == CHN - 1) begin m_busy = 0; m_last = m_mod; m_done++; end
         else m_ch++;
      end
      @(posedge clk); #1;
      cyc++;
   endtask

   task automatic reset_dut();
      rst_n = 1'b0; req = 3'b000; tick(); rst_n = 1'b1; clear_logs();
   endtask

   task automatic run_until_done(int want, int bound);
      int k = 0;
      while (obs_done_cnt < want && k < bound) begin tick(); k++; end
      n_cmp++; if (obs_done_cnt < want) begin n_err++; $display("FAIL timeout_done got=%0d exp=%0d", obs_done_cnt, want); end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; req = 3'b111;
      @(posedge clk); #1;
      chk_en = 1;
      tick();
      n_cmp++; if (grant !== 3'b000) begin n_err++; $display("FAIL rst_grant got=%b exp=000", grant); end
      n_cmp++; if (done !== 3'b000) begin n_err++; $display("FAIL rst_done got=%b exp=000", done); end
      n_cmp++; if (busy !== 1'b0 || sreq !== 1'b0 || dvalid !== 1'b0) begin n_err++; $display("FAIL rst_flags got=%b%b%b exp=000", busy, sreq, dvalid); end
      n_cmp++; if (saddr !== '0) begin n_err++; $display("FAIL rst_addr got=%h exp=0", saddr); end
      n_cmp++; if (dout !== '0 || dmod !== 2'd0 || dch !== '0) begin n_err++; $display("FAIL rst_data got=%h/%0d/%0d exp=0", dout[31:0], dmod, dch); end
      req = 3'b000; rst_n = 1'b1; tick(); clear_logs();
   endtask

   task automatic test_single();
      reset_dut();
      req = 3'b001;
      run_until_done(1, 60);
      req = 3'b000;
      repeat (3) tick();
      n_cmp++; if (obs_done_cnt != 1 || obs_done_val !== 3'b001) begin n_err++; $display("FAIL single_done got=%0d/%b exp=1/001", obs_done_cnt, obs_done_val); end
      // decision cycle is one before the first granted cycle
      n_cmp++; if (obs_done_cyc - obs_grant_cyc + 1 != 12) begin n_err++; $display("FAIL single_latency got=%0d exp=12", obs_done_cyc - obs_grant_cyc + 1); end
      n_cmp++; if (obs_addr_q.size() != 4) begin n_err++; $display("FAIL single_nreads got=%0d exp=4", obs_addr_q.size()); end
      for (int i = 0; i < 4 && i < obs_addr_q.size() && i < obs_ch_q.size(); i++) begin
         n_cmp++; if (obs_addr_q[i] != i || obs_ch_q[i] != i) begin n_err++; $display("FAIL single_seq i=%0d got=%0d/%0d exp=%0d", i, obs_addr_q[i], obs_ch_q[i], i); end
      end
      n_cmp++; if (obs_grant_cnt != 12 || obs_frame_q.size() != 1) begin n_err++; $display("FAIL single_grant got=%0d/%0d exp=12/1", obs_grant_cnt, obs_frame_q.size()); end
   endtask

   task automatic test_round_robin();
      int exp_g[4] = '{1, 2, 4, 1};
      reset_dut();
      req = 3'b111;
      run_until_done(4, 120);
      req = 3'b000;
      tick();
      n_cmp++; if (obs_frame_q.size() != 4 || obs_addr_q.size() != 16) begin n_err++; $display("FAIL rr_counts got=%0d/%0d exp=4/16", obs_frame_q.size(), obs_addr_q.size()); end
      for (int i = 0; i < 4 && i < obs_frame_q.size() && 4 * i < obs_addr_q.size(); i++) begin
         n_cmp++; if (obs_frame_q[i] != exp_g[i] || (obs_addr_q[4*i] >> CHW) != i % 3) begin
            n_err++; $display("FAIL rr_order i=%0d got=%0d/%0d exp=%0d/%0d", i, obs_frame_q[i], obs_addr_q[4*i] >> CHW, exp_g[i], i % 3);
         end
      end
   endtask

   task automatic test_back_pressure();
      int k = 0;
      reset_dut();
      req = 3'b001;
      while (!(dvalid === 1'b1 && dch === 2'd1) && k < 40) begin tick(); k++; end
      n_cmp++; if (k >= 40) begin n_err++; $display("FAIL bp_timeout got=%0d exp<40", k); end
      dready_hold = 5;
      for (int i = 0; i < 5; i++) begin
         tick();
         n_cmp++; if (dvalid !== 1'b1 || dch !== 2'd1 || dmod !== 2'd0 || dout !== m_word || sreq !== 1'b0) begin
            n_err++; $display("FAIL bp_stall i=%0d got=v%b ch%0d req%b exp=v1 ch1 req0", i, dvalid, dch, sreq);
         end
      end
      tick();
      n_cmp++; if (sreq !== 1'b1 || saddr !== 4'h2) begin n_err++; $display("FAIL bp_next got=%b/%h exp=1/2", sreq, saddr); end
      run_until_done(1, 40);
      req = 3'b000; tick();
   endtask

   task automatic test_sram_delays();
      reset_dut();
      ready_lat = 3; valid_lat = 4; spurious = 1;
      req = 3'b001;
      run_until_done(1, 200);
      req = 3'b000; tick();
      n_cmp++; if (obs_sreq_cyc != 16) begin n_err++; $display("FAIL delay_req_cycles got=%0d exp=16", obs_sreq_cyc); end
      n_cmp++; if (obs_acc_cnt != 4 || obs_done_val !== 3'b001) begin n_err++; $display("FAIL delay_words got=%0d/%b exp=4/001", obs_acc_cnt, obs_done_val); end
      ready_lat = 0; valid_lat = 0; spurious = 0;
   endtask

   task automatic test_req_drop();
      int k = 0;
      reset_dut();
      req = 3'b010;
      while (obs_acc_cnt < 1 && k < 40) begin tick(); k++; end
      req = 3'b000;
      run_until_done(1, 60);
      tick();
      n_cmp++; if (obs_done_val !== 3'b010 || obs_done_cnt != 1) begin n_err++; $display("FAIL drop_done got=%b/%0d exp=010/1", obs_done_val, obs_done_cnt); end
      n_cmp++; if (obs_ch_q.size() != 4 || obs_frame_q.size() != 1 || obs_frame_q[0] != 2) begin
         n_err++; $display("FAIL drop_frame got=%0d words exp=4 words of mod1", obs_ch_q.size());
      end
   endtask

   task automatic test_reset_midframe();
      int k = 0;
      reset_dut();
      valid_lat = 3;
      req = 3'b100;
      while (!(obs_addr_q.size() == 3 && busy === 1'b1 && sreq === 1'b0 && dvalid === 1'b0) && k < 60) begin tick(); k++; end
      n_cmp++; if (k >= 60) begin n_err++; $display("FAIL mid_timeout got=%0d exp<60", k); end
      rst_n = 1'b0; tick(); rst_n = 1'b1;
      n_cmp++; if (grant !== 3'b000 || busy !== 1'b0 || sreq !== 1'b0 || dvalid !== 1'b0 || done !== 3'b000) begin
         n_err++; $display("FAIL mid_outputs got=g%b b%b r%b v%b d%b exp=0", grant, busy, sreq, dvalid, done);
      end
      n_cmp++; if (dout !== '0 || dmod !== 2'd0 || dch !== '0 || obs_done_cnt != 0) begin n_err++; $display("FAIL mid_data got=%h/%0d exp=0/0", dout[31:0], obs_done_cnt); end
      clear_logs();
      k = 0;
      while (obs_addr_q.size() < 1 && k < 20) begin tick(); k++; end
      n_cmp++; if (obs_addr_q.size() < 1 || obs_addr_q[0] != 8) begin n_err++; $display("FAIL mid_restart got=%0d exp=8", obs_addr_q.size() > 0 ? obs_addr_q[0] : -1); end
      run_until_done(1, 60);
      req = 3'b000; tick();
      n_cmp++; if (obs_done_val !== 3'b100) begin n_err++; $display("FAIL mid_done got=%b exp=100", obs_done_val); end
      valid_lat = 0;
   endtask

   task automatic test_random();
      int k = 0;
      reset_dut();
      p_sready = 60; p_dready = 50; valid_rand = 1; valid_lat = 3; spurious = 1;
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(7) == 0) req = 3'($urandom_range(7));
         tick();
      end
      req = 3'b000;
      while (m_busy && k < 300) begin tick(); k++; end
      n_cmp++; if (obs_done_cnt != m_done || obs_done_cnt == 0) begin n_err++; $display("FAIL rand_frames got=%0d exp=%0d (nonzero)", obs_done_cnt, m_done); end
      n_cmp++; if (obs_acc_cnt != CHN * m_done) begin n_err++; $display("FAIL rand_words got=%0d exp=%0d", obs_acc_cnt, CHN * m_done); end
      p_sready = 100; p_dready = 100; valid_rand = 0; valid_lat = 0; spurious = 0;
   endtask

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_back_pressure();
      test_sram_delays();
      test_req_drop();
      test_reset_midframe();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
